// File: rtl/fpga_io_mux.sv
// Board pad multiplexer: per-pad function select, synchronised pad inputs and a
// lock-driven SoC reset sequencer that keeps every pad tristated until RUN.
module fpga_io_mux #(
   parameter int PAD_NUM     = 8,
   parameter int FUNC_NUM    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int RST_HOLD    = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          locked_i,
   output logic                          soc_rst_n_o,
   input  logic                          cfg_valid_i,
   output logic                          cfg_ready_o,
   input  logic [$clog2(PAD_NUM)-1:0]    cfg_pad_i,
   input  logic [$clog2(FUNC_NUM)-1:0]   cfg_func_i,
   input  logic [FUNC_NUM*PAD_NUM-1:0]   fn_out_i,
   input  logic [FUNC_NUM*PAD_NUM-1:0]   fn_oen_i,
   output logic [FUNC_NUM*PAD_NUM-1:0]   fn_in_o,
   input  logic [PAD_NUM-1:0]            pad_in_i,
   output logic [PAD_NUM-1:0]            pad_out_o,
   output logic [PAD_NUM-1:0]            pad_oen_o,
   output logic [1:0]                    fsm_state_o
);

   localparam int PW = $clog2(PAD_NUM);
   localparam int FW = $clog2(FUNC_NUM);
   localparam int CW = $clog2(RST_HOLD + 1);
   localparam int IW = SYNC_STAGES * PAD_NUM;
   localparam logic [PW:0]   PAD_LIM   = PAD_NUM[PW:0];
   localparam logic [FW:0]   FUNC_LIM  = FUNC_NUM[FW:0];
   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    soc_rst_n_q, soc_rst_n_d;
   logic [SYNC_STAGES-1:0]  lock_sync_q, lock_sync_d;
   logic [IW-1:0]           in_sync_q, in_sync_d;
   logic [FW-1:0]           sel_q [PAD_NUM];
   logic [FW-1:0]           sel_d [PAD_NUM];
   logic                    cfg_ready_q, cfg_ready_d;
   logic                    lock_s;
   logic [PAD_NUM-1:0]      in_s;
   logic                    cfg_fire;
   logic                    cfg_in_range;
   logic                    run;

   // Synchronisers shift towards the MSB; the oldest stage is the usable value.
   always_comb begin
      lock_sync_d = (lock_sync_q << 1) | SYNC_STAGES'(locked_i);
      in_sync_d   = (in_sync_q << PAD_NUM) | IW'(pad_in_i);
   end

   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   assign in_s   = in_sync_q[IW-1 -: PAD_NUM];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      soc_rst_n_d = soc_rst_n_q;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d     = RUN;
               soc_rst_n_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d     = WAIT_LOCK;
               cnt_d       = '0;
               soc_rst_n_d = 1'b0;
            end
         end
         default: begin
            state_d     = WAIT_LOCK;
            cnt_d       = '0;
            soc_rst_n_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         soc_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         soc_rst_n_q <= soc_rst_n_d;
      end
   end

   // Config handshake: a write completes on any edge with cfg_valid_i and
   // cfg_ready_o both high; ready then drops for exactly one cycle.
   assign cfg_fire     = cfg_valid_i & cfg_ready_q;
   assign cfg_in_range = ({1'b0, cfg_pad_i} < PAD_LIM) && ({1'b0, cfg_func_i} < FUNC_LIM);

   always_comb begin
      sel_d       = sel_q;
      cfg_ready_d = ~cfg_fire;
      if (cfg_fire && cfg_in_range) begin
         sel_d[cfg_pad_i] = cfg_func_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_sync_q <= '0;
         in_sync_q   <= '1;
         sel_q       <= '{default: '0};
         cfg_ready_q <= 1'b1;
      end else begin
         lock_sync_q <= lock_sync_d;
         in_sync_q   <= in_sync_d;
         sel_q       <= sel_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign run = (state_q == RUN);

   for (genvar p = 0; p < PAD_NUM; p++) begin : g_pad
      logic [FUNC_NUM-1:0] fo;
      logic [FUNC_NUM-1:0] fe;
      for (genvar f = 0; f < FUNC_NUM; f++) begin : g_fn
         assign fo[f] = fn_out_i[f*PAD_NUM + p];
         assign fe[f] = fn_oen_i[f*PAD_NUM + p];
         // Unselected functions see an idle-high input.
         assign fn_in_o[f*PAD_NUM + p] = (sel_q[p] == FW'(f)) ? in_s[p] : 1'b1;
      end
      assign pad_out_o[p] = fo[sel_q[p]];
      assign pad_oen_o[p] = run ? fe[sel_q[p]] : 1'b1;
   end

   assign soc_rst_n_o = soc_rst_n_q;
   assign cfg_ready_o = cfg_ready_q;
   assign fsm_state_o = state_q;

endmodule

// File: tb/tb_fpga_io_mux.sv
// Self-checking bench for fpga_io_mux: reset sequencing, pad select writes,
// output/enable muxing and the synchronised input path.
module tb_fpga_io_mux;

   logic        clk;
   logic        rst_n;
   logic        locked;
   logic        cfg_valid, cfg_ready;
   logic [2:0]  cfg_pad;
   logic [1:0]  cfg_func;
   logic [31:0] fn_out, fn_oen, fn_in;
   logic [7:0]  pad_in, pad_out, pad_oen;
   logic        soc_rst_n;
   logic [1:0]  fsm_state;

   logic        cfg3_valid, cfg3_ready;
   logic [2:0]  cfg3_pad;
   logic [1:0]  cfg3_func;
   logic [23:0] fn3_out, fn3_oen, fn3_in;
   logic [7:0]  pad3_out, pad3_oen;
   logic        soc3_rst_n;
   logic [1:0]  fsm3_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   int          sel_m [8];

   fpga_io_mux #(.PAD_NUM(8), .FUNC_NUM(4), .SYNC_STAGES(2), .RST_HOLD(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .locked_i(locked), .soc_rst_n_o(soc_rst_n),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_pad_i(cfg_pad),
      .cfg_func_i(cfg_func), .fn_out_i(fn_out), .fn_oen_i(fn_oen), .fn_in_o(fn_in),
      .pad_in_i(pad_in), .pad_out_o(pad_out), .pad_oen_o(pad_oen),
      .fsm_state_o(fsm_state)
   );

   fpga_io_mux #(.PAD_NUM(8), .FUNC_NUM(3), .SYNC_STAGES(2), .RST_HOLD(16)) dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .locked_i(locked), .soc_rst_n_o(soc3_rst_n),
      .cfg_valid_i(cfg3_valid), .cfg_ready_o(cfg3_ready), .cfg_pad_i(cfg3_pad),
      .cfg_func_i(cfg3_func), .fn_out_i(fn3_out), .fn_oen_i(fn3_oen), .fn_in_o(fn3_in),
      .pad_in_i(pad_in), .pad_out_o(pad3_out), .pad_oen_o(pad3_oen),
      .fsm_state_o(fsm3_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input string tag, input logic [31:0] got);
      if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      else check_eq(tag, got, exp_q.pop_front());
   endtask

   function automatic logic [7:0] m_pad_out(input logic [31:0] fo);
      logic [7:0] r;
      for (int p = 0; p < 8; p++) r[p] = fo[sel_m[p]*8 + p];
      return r;
   endfunction

   function automatic logic [7:0] m_pad_oen(input logic [31:0] fe, input logic is_run);
      logic [7:0] r;
      r = 8'hff;
      if (is_run) for (int p = 0; p < 8; p++) r[p] = fe[sel_m[p]*8 + p];
      return r;
   endfunction

   function automatic logic [31:0] m_fn_in(input logic [7:0] ins);
      logic [31:0] r;
      for (int f = 0; f < 4; f++)
         for (int p = 0; p < 8; p++)
            r[f*8 + p] = (sel_m[p] == f) ? ins[p] : 1'b1;
      return r;
   endfunction

   // Driver: hold a write request until accepted; returns cycles spent waiting.
   task automatic cfg_write(input int pad, input int func, output int waits);
      cfg_valid = 1'b1;
      cfg_pad   = 3'(pad);
      cfg_func  = 2'(func);
      waits     = 0;
      while (cfg_ready !== 1'b1 && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      if (cfg_ready !== 1'b1) check_eq("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
      @(negedge clk);
      if (pad < 8 && func < 4) sel_m[pad] = func;
   endtask

   task automatic cfg3_write(input int pad, input int func);
      int waits;
      cfg3_valid = 1'b1;
      cfg3_pad   = 3'(pad);
      cfg3_func  = 2'(func);
      waits      = 0;
      while (cfg3_ready !== 1'b1 && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      if (cfg3_ready !== 1'b1) check_eq("cfg3_ready_timeout", 32'(cfg3_ready), 32'd1);
      @(negedge clk);
      cfg3_valid = 1'b0;
   endtask

   // Drive a pattern that is 1 only on each pad's selected function, then its inverse.
   task automatic probe_sel(input string tag);
      logic [31:0] pat;
      pat = '0;
      for (int p = 0; p < 8; p++) pat[sel_m[p]*8 + p] = 1'b1;
      fn_out = pat;
      sb_push(32'h0000_00ff);
      #1 sb_check({tag, "_ones"}, 32'(pad_out));
      fn_out = ~pat;
      sb_push(32'h0000_0000);
      #1 sb_check({tag, "_zeros"}, 32'(pad_out));
   endtask

   // Called on the negedge where the lock/reset trigger was applied.
   task automatic check_rise_timing(input string tag);
      logic early, oen_bad;
      early   = 1'b0;
      oen_bad = 1'b0;
      for (int e = 1; e <= 18; e++) begin
         @(negedge clk);
         if (soc_rst_n !== 1'b0) early = 1'b1;
         if (pad_oen !== 8'hff) oen_bad = 1'b1;
      end
      check_eq({tag, "_early"}, 32'(early), 32'd0);
      check_eq({tag, "_oen_hiz"}, 32'(oen_bad), 32'd0);
      @(negedge clk);
      check_eq({tag, "_rise"}, 32'(soc_rst_n), 32'd1);
      check_eq({tag, "_state"}, 32'(fsm_state), 32'd2);
   endtask

   initial begin
      int          w0, w1;
      logic [7:0]  pin;
      logic        prev5;

      rst_n      = 1'b0;
      locked     = 1'b1;
      cfg_valid  = 1'b0;
      cfg_pad    = '0;
      cfg_func   = '0;
      fn_out     = $urandom;
      fn_oen     = $urandom;
      pad_in     = 8'hff;
      cfg3_valid = 1'b0;
      cfg3_pad   = '0;
      cfg3_func  = '0;
      fn3_out    = {8'h00, 8'hff, 8'h00};
      fn3_oen    = '0;
      for (int p = 0; p < 8; p++) sel_m[p] = 0;

      repeat (3) @(negedge clk);
      check_eq("rst_soc", 32'(soc_rst_n), 32'd0);
      check_eq("rst_ready", 32'(cfg_ready), 32'd1);
      check_eq("rst_oen", 32'(pad_oen), 32'h0000_00ff);
      check_eq("rst_state", 32'(fsm_state), 32'd0);
      check_eq("rst_fn_in", fn_in, 32'hffff_ffff);
      sb_push(32'(m_pad_out(fn_out)));
      sb_check("rst_pad_out", 32'(pad_out));

      rst_n = 1'b1;
      check_rise_timing("por");
      sb_push(32'(m_pad_oen(fn_oen, 1'b1)));
      sb_check("run_oen", 32'(pad_oen));

      // Pad 3 on function 2 drives bit 19 out with its enable active.
      fn_out = $urandom | 32'h0008_0000;
      fn_oen = $urandom & ~32'h0008_0000;
      cfg_write(3, 2, w0);
      cfg_valid = 1'b0;
      check_eq("w3_wait", 32'(w0), 32'd0);
      check_eq("w3_rdy_low", 32'(cfg_ready), 32'd0);
      check_eq("w3_pad_out3", 32'(pad_out[3]), 32'd1);
      check_eq("w3_pad_oen3", 32'(pad_oen[3]), 32'd0);
      sb_push(32'(m_pad_out(fn_out)));
      sb_check("w3_pad_out", 32'(pad_out));
      sb_push(32'(m_pad_oen(fn_oen, 1'b1)));
      sb_check("w3_pad_oen", 32'(pad_oen));
      @(negedge clk);
      check_eq("w3_rdy_back", 32'(cfg_ready), 32'd1);

      for (int k = 0; k < 4; k++) begin
         fn_out = $urandom;
         fn_oen = $urandom;
         sb_push(32'(m_pad_out(fn_out)));
         sb_push(32'(m_pad_oen(fn_oen, 1'b1)));
         #1;
         sb_check("rnd_pad_out", 32'(pad_out));
         sb_check("rnd_pad_oen", 32'(pad_oen));
      end

      // Back-to-back requests: the second waits out the ready-low cycle.
      @(negedge clk);
      cfg_write(0, 1, w0);
      cfg_write(1, 3, w1);
      cfg_valid = 1'b0;
      check_eq("b2b_first_wait", 32'(w0), 32'd0);
      check_eq("b2b_second_wait", 32'(w1), 32'd1);
      check_eq("b2b_rdy_low", 32'(cfg_ready), 32'd0);
      probe_sel("b2b");

      // Input path: gating switches on the write edge, data lags two edges.
      @(negedge clk);
      pad_in = 8'hdf;
      repeat (2) @(negedge clk);
      cfg_write(5, 1, w0);
      cfg_valid = 1'b0;
      sb_push(m_fn_in(8'hdf));
      sb_check("gate_same_edge", fn_in);
      probe_sel("p5");
      prev5 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pin    = 8'($urandom);
         pin[5] = ~prev5;
         pad_in = pin;
         sb_push(m_fn_in(pin));
         @(negedge clk);
         check_eq("in_lat1", 32'(fn_in[13]), 32'(prev5));
         @(negedge clk);
         sb_check("in_sync", fn_in);
         check_eq("in_other_fn", 32'({fn_in[29], fn_in[21], fn_in[5]}), 32'd7);
         prev5 = pin[5];
      end

      // FUNC_NUM = 3 instance: out-of-range function completes without effect.
      cfg3_write(2, 1);
      check_eq("f3_rdy_low", 32'(cfg3_ready), 32'd0);
      sb_push(32'h0000_0004);
      sb_check("f3_sel1", 32'(pad3_out));
      @(negedge clk);
      cfg3_write(2, 3);
      check_eq("f3_bad_rdy_low", 32'(cfg3_ready), 32'd0);
      sb_push(32'h0000_0004);
      sb_check("f3_bad_nochange", 32'(pad3_out));

      // Lock drops for three sampled cycles while in RUN.
      @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      check_eq("drop_e1", 32'(soc_rst_n), 32'd1);
      @(negedge clk);
      check_eq("drop_e2", 32'(soc_rst_n), 32'd1);
      @(negedge clk);
      check_eq("drop_e3", 32'(soc_rst_n), 32'd0);
      check_eq("drop_oen", 32'(pad_oen), 32'h0000_00ff);
      check_eq("drop_state", 32'(fsm_state), 32'd0);
      locked = 1'b1;
      check_rise_timing("relock");
      probe_sel("relock_sel");

      // Asynchronous reset in RUN, then again part-way through HOLD.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_soc", 32'(soc_rst_n), 32'd0);
      check_eq("arst_ready", 32'(cfg_ready), 32'd1);
      check_eq("arst_oen", 32'(pad_oen), 32'h0000_00ff);
      check_eq("arst_state", 32'(fsm_state), 32'd0);
      check_eq("arst_fn_in", fn_in, 32'hffff_ffff);
      for (int p = 0; p < 8; p++) sel_m[p] = 0;
      probe_sel("arst_sel");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("hold_mid_state", 32'(fsm_state), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("hold_arst_state", 32'(fsm_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_rise_timing("rst_hold");

      check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fpga_io_mux.md
FPGA_IO_MUX -- requirements
Module: fpga_io_mux

Interface
REQ-001 SHALL have parameter PAD_NUM, default 8, number of bidirectional board pads.
REQ-002 SHALL have parameter FUNC_NUM, default 4, functions per pad; func 0 = GPIO, 1..FUNC_NUM-1 = alternate peripherals.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flop stages on every asynchronous input.
REQ-004 SHALL have parameter RST_HOLD, default 16, SoC reset hold cycles after clock lock.
REQ-005 SHALL have port clk_i  in  1  system clock; single clock domain.
REQ-006 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port locked_i  in  1  clock-generator lock, asynchronous.
REQ-008 SHALL have port soc_rst_n_o  out  1  registered SoC reset, active-low.
REQ-009 SHALL have port cfg_valid_i  in  1  config write request.
REQ-010 SHALL have port cfg_ready_o  out  1  config write accept.
REQ-011 SHALL have port cfg_pad_i  in  $clog2(PAD_NUM)  target pad index.
REQ-012 SHALL have port cfg_func_i  in  $clog2(FUNC_NUM)  function to select.
REQ-013 SHALL have port fn_out_i  in  FUNC_NUM*PAD_NUM  output value; bit f*PAD_NUM+p = function f, pad p.
REQ-014 SHALL have port fn_oen_i  in  FUNC_NUM*PAD_NUM  output enable, active-low, same indexing.
REQ-015 SHALL have port fn_in_o  out  FUNC_NUM*PAD_NUM  synchronised pad input per function, same indexing.
REQ-016 SHALL have ports pad_in_i in, pad_out_o out, pad_oen_o out, each PAD_NUM wide, to the tristate pad cells.

Function
REQ-017 SHALL pass locked_i through SYNC_STAGES flops (lock_s) before use.
REQ-018 SHALL run a reset FSM with states WAIT_LOCK, HOLD, RUN; soc_rst_n_o = 1 only in RUN.
REQ-019 WAIT_LOCK -> HOLD when lock_s = 1; hold counter cleared on entry.
REQ-020 HOLD SHALL count RST_HOLD cycles, then -> RUN; lock_s = 0 in HOLD -> WAIT_LOCK, counter cleared.
REQ-021 RUN -> WAIT_LOCK when lock_s = 0; soc_rst_n_o SHALL fall on the same edge the FSM leaves RUN.
REQ-022 locked_i held high from reset release SHALL yield soc_rst_n_o rising exactly SYNC_STAGES+RST_HOLD+1 clk_i edges after the first edge sampling locked_i = 1.
REQ-023 SHALL hold a per-pad select register sel[p], $clog2(FUNC_NUM) bits.
REQ-024 A write SHALL complete on an edge where cfg_valid_i and cfg_ready_o are both 1; sel[cfg_pad_i] updates on that edge.
REQ-025 cfg_ready_o SHALL be 0 for exactly the one cycle after a completed write, 1 otherwise; independent of FSM state.
REQ-026 A write with cfg_pad_i >= PAD_NUM or cfg_func_i >= FUNC_NUM SHALL complete the handshake with no register change.
REQ-027 pad_out_o[p] SHALL combinationally equal fn_out_i[sel[p]*PAD_NUM+p].
REQ-028 pad_oen_o[p] SHALL equal fn_oen_i[sel[p]*PAD_NUM+p] in RUN and SHALL be forced 1 (hi-Z) outside RUN.
REQ-029 pad_in_i SHALL pass through SYNC_STAGES flops (in_s); fn_in_o[f*PAD_NUM+p] = in_s[p] if sel[p] == f, else 1.
REQ-030 A select change SHALL redirect pad outputs in the cycle after the write edge and the input-path gating on that same edge; no glitch filtering required.

Reset
REQ-031 rst_n_i low SHALL asynchronously set: FSM = WAIT_LOCK, counter = 0, all sync flops lock_s = 0 and in_s = 1, all sel = 0, soc_rst_n_o = 0, cfg_ready_o = 1, pad_oen_o all 1.
REQ-032 rst_n_i assertion mid-HOLD or mid-RUN SHALL abort immediately with no partial state retained; reset deassertion is synchronised externally.

Verification
REQ-033 Defaults, locked_i = 1 at reset release -> soc_rst_n_o rises on edge 19; pad_oen_o all 1 until then.
REQ-034 In RUN, locked_i pulses low 3 cycles -> soc_rst_n_o low 2 edges after fall, re-rises 19 edges after locked_i returns high.
REQ-035 Write pad 3 func 2, fn_out_i bit 19 = 1, fn_oen_i bit 19 = 0 -> pad_out_o[3] = 1, pad_oen_o[3] = 0; cfg_ready_o low one cycle.
REQ-036 Back-to-back cfg_valid_i for pad 0 then pad 1 -> second write accepted one cycle late; both sel values correct.
REQ-037 cfg_func_i = 3 with FUNC_NUM = 3 (parameter override) -> handshake completes, sel unchanged.
REQ-038 pad 5 sel = 1, pad_in_i[5] toggles -> fn_in_o bit 13 follows after 2 edges; bits 5, 21, 29 stay 1.
